// File: rtl/parser_input_arbiter.sv
`timescale 1ns/1ps
// Shares the escape-sequence parser's byte input between host receive (source 0) and a local
// generator (source 1): per-source FIFOs, round-robin grant, ESC-sequence lock and issue pacing.
module parser_input_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ISSUE_GAP    = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] loc_data,
    input  logic       loc_valid,
    output logic       loc_ready,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       lock_active,
    output logic       lock_owner,
    output logic       lock_timeout
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(ISSUE_GAP + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_OPEN, S_ESC1, S_CSI, S_SCS} lock_state_t;

    logic [7:0]       r_mem    [2][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [CNT_W-1:0] r_cnt    [2];
    logic [GAP_W-1:0] r_gap;
    logic [TO_W-1:0]  r_to_cnt;
    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [7:0]       r_data;
    logic             r_data_ready;
    logic             r_owner;
    logic             r_lock_timeout;

    logic [7:0]       w_din [2];
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic             w_sel;
    logic             w_issue;
    logic             w_to_fire;
    logic [7:0]       w_head;

    assign w_din[0] = rx_data;
    assign w_din[1] = loc_data;

    assign w_full  = {r_cnt[1] == CNT_W'(FIFO_DEPTH), r_cnt[0] == CNT_W'(FIFO_DEPTH)};
    assign w_empty = {r_cnt[1] == '0, r_cnt[0] == '0};
    assign w_push  = {loc_valid & ~w_full[1], rx_valid & ~w_full[0]};

    // Locked: only the owner may issue. Open: a lone non-empty FIFO wins, a tie goes away from the last grant.
    always_comb begin
        w_sel = r_owner;
        if (r_state == S_OPEN) begin
            if (!w_empty[0] && w_empty[1])
                w_sel = 1'b0;
            else if (w_empty[0] && !w_empty[1])
                w_sel = 1'b1;
            else if (!w_empty[0] && !w_empty[1])
                w_sel = ~r_owner;
        end
    end

    assign w_issue   = (r_gap == '0) && !w_empty[w_sel];
    assign w_pop     = {w_issue & w_sel, w_issue & ~w_sel};
    assign w_head    = r_mem[w_sel][r_rd_ptr[w_sel]];
    assign w_to_fire = (r_state != S_OPEN) && w_empty[r_owner] &&
                       (r_to_cnt == TO_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (w_to_fire) begin
            w_state_nxt = S_OPEN;
        end else if (w_issue) begin
            case (r_state)
                S_OPEN: if (w_head == 8'h1B) w_state_nxt = S_ESC1;
                S_ESC1: begin
                    if (w_head == 8'h5B)
                        w_state_nxt = S_CSI;
                    else if (w_head == 8'h28 || w_head == 8'h29)
                        w_state_nxt = S_SCS;
                    else if (w_head == 8'h1B)
                        w_state_nxt = S_ESC1;
                    else
                        w_state_nxt = S_OPEN;
                end
                S_CSI: begin
                    if (w_head == 8'h1B)
                        w_state_nxt = S_ESC1;
                    else if (w_head >= 8'h40 && w_head <= 8'h7E)
                        w_state_nxt = S_OPEN;
                end
                S_SCS: w_state_nxt = (w_head == 8'h1B) ? S_ESC1 : S_OPEN;
                default: w_state_nxt = S_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s])
                r_mem[s][r_wr_ptr[s]] <= w_din[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                r_wr_ptr[s] <= '0;
                r_rd_ptr[s] <= '0;
                r_cnt[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s])
                    r_wr_ptr[s] <= r_wr_ptr[s] + PTR_W'(1);
                if (w_pop[s])
                    r_rd_ptr[s] <= r_rd_ptr[s] + PTR_W'(1);
                if (w_push[s] && !w_pop[s])
                    r_cnt[s] <= r_cnt[s] + CNT_W'(1);
                else if (!w_push[s] && w_pop[s])
                    r_cnt[s] <= r_cnt[s] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap          <= '0;
            r_to_cnt       <= '0;
            r_state        <= S_OPEN;
            r_data         <= 8'h00;
            r_data_ready   <= 1'b0;
            r_owner        <= 1'b1;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_data_ready   <= w_issue;
            r_lock_timeout <= w_to_fire;
            if (w_issue) begin
                r_data  <= w_head;
                r_owner <= w_sel;
                r_gap   <= GAP_W'(ISSUE_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            // The stall clock only runs while the owner has nothing queued.
            if (r_state == S_OPEN || w_issue || w_to_fire)
                r_to_cnt <= '0;
            else if (w_empty[r_owner])
                r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign rx_ready     = ~w_full[0];
    assign loc_ready    = ~w_full[1];
    assign data         = r_data;
    assign dataReady    = r_data_ready;
    assign lock_active  = (r_state != S_OPEN);
    assign lock_owner   = r_owner;
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_parser_input_arbiter.sv
`timescale 1ns/1ps
// Bench for parser_input_arbiter: a queue-based reference model predicts every issue into a
// scoreboard that a monitor drains on each dataReady strobe; directed scenarios plus random traffic.
module tb_parser_input_arbiter;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int LT    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] loc_data = 8'h00;
    logic       loc_valid = 1'b0;
    logic       loc_ready;
    logic [7:0] data;
    logic       dataReady;
    logic       lock_active;
    logic       lock_owner;
    logic       lock_timeout;

    parser_input_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .ISSUE_GAP   (GAP),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .loc_data    (loc_data),
        .loc_valid   (loc_valid),
        .loc_ready   (loc_ready),
        .data        (data),
        .dataReady   (dataReady),
        .lock_active (lock_active),
        .lock_owner  (lock_owner),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int mcyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, mcyc);
    endtask

    // Reference model: FIFOs as queues, the escape lock as the bytes of the sequence in progress.
    typedef struct {
        byte unsigned b;
        int           c;
    } exp_t;

    byte unsigned mq0[$];
    byte unsigned mq1[$];
    byte unsigned m_esc[$];
    exp_t         exp_q[$];
    int           m_gap;
    int           m_to;
    bit           m_owner;
    bit           m_issued;
    bit           m_fire;
    byte unsigned m_data;

    function automatic int qsize(input bit s);
        return s ? mq1.size() : mq0.size();
    endfunction

    function automatic void esc_advance(input byte unsigned b);
        if (b == 8'h1B) begin
            m_esc.delete();
            m_esc.push_back(b);
        end else if (m_esc.size() != 0) begin
            m_esc.push_back(b);
            if (m_esc.size() == 2) begin
                if (!(b == 8'h5B || b == 8'h28 || b == 8'h29))
                    m_esc.delete();
            end else if (m_esc[1] != 8'h5B) begin
                m_esc.delete();
            end else if (b >= 8'h40 && b <= 8'h7E) begin
                m_esc.delete();
            end
        end
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_esc.delete();
        exp_q.delete();
        m_gap    = 0;
        m_to     = 0;
        m_owner  = 1'b1;
        m_issued = 1'b0;
        m_fire   = 1'b0;
        m_data   = 8'h00;
    endtask

    task automatic model_step();
        bit locked, sel, issue, fire, own_empty, p0, p1;
        byte unsigned b;
        exp_t e;
        mcyc++;
        locked    = (m_esc.size() != 0);
        own_empty = (qsize(m_owner) == 0);
        if (locked)                               sel = m_owner;
        else if (mq0.size() != 0 && mq1.size() != 0) sel = !m_owner;
        else if (mq0.size() != 0)                 sel = 1'b0;
        else if (mq1.size() != 0)                 sel = 1'b1;
        else                                      sel = m_owner;
        issue = (m_gap == 0) && (qsize(sel) != 0);
        fire  = locked && own_empty && (m_to == LT - 1);
        p0    = rx_valid && (mq0.size() < DEPTH);
        p1    = loc_valid && (mq1.size() < DEPTH);
        if (issue) begin
            if (sel) b = mq1.pop_front();
            else     b = mq0.pop_front();
            m_data  = b;
            e.b     = b;
            e.c     = mcyc;
            exp_q.push_back(e);
            m_owner = sel;
            m_gap   = GAP;
            esc_advance(b);
        end else if (m_gap > 0) begin
            m_gap--;
        end
        if (fire) m_esc.delete();
        if (!locked || issue || fire) m_to = 0;
        else if (own_empty)           m_to++;
        if (p0) mq0.push_back(rx_data);
        if (p1) mq1.push_back(loc_data);
        m_issued = issue;
        m_fire   = fire;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    byte unsigned obs_log[$];
    int           obs_cyc[$];
    int           to_log[$];
    bit           saw_loc_full = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("dataReady", dataReady, m_issued);
                chk("data", data, m_data);
                chk("lock_active", lock_active, m_esc.size() != 0);
                chk("lock_owner", lock_owner, m_owner);
                chk("lock_timeout", lock_timeout, m_fire);
                chk("rx_ready", rx_ready, mq0.size() < DEPTH);
                chk("loc_ready", loc_ready, mq1.size() < DEPTH);
                if (!loc_ready) saw_loc_full = 1'b1;
                if (lock_timeout) to_log.push_back(mcyc);
                if (dataReady) begin
                    obs_log.push_back(data);
                    obs_cyc.push_back(mcyc);
                    if (exp_q.size() == 0) begin
                        note_fail("sb_underflow", "dataReady with no expected byte");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_byte", data, e.b);
                        chk("sb_cycle", mcyc, e.c);
                    end
                end
            end
        end
    end

    byte unsigned stim0[$];
    byte unsigned stim1[$];
    byte unsigned dir_exp[$];

    function automatic void add(input bit s, input byte unsigned b);
        if (s) stim1.push_back(b);
        else   stim0.push_back(b);
    endfunction

    function automatic void dexp(input byte unsigned b);
        dir_exp.push_back(b);
    endfunction

    function automatic byte unsigned pick();
        byte unsigned v;
        case ($urandom_range(0, 11))
            0, 1:    v = 8'h1B;
            2:       v = 8'h5B;
            3:       v = 8'h28;
            4:       v = 8'h29;
            5:       v = 8'h31;
            6:       v = 8'h3B;
            7:       v = 8'h48;
            8:       v = 8'h40;
            9:       v = 8'h7E;
            10:      v = 8'h7F;
            default: v = 8'($urandom_range(0, 255));
        endcase
        return v;
    endfunction

    task automatic drive(input bit s, input bit v, input byte unsigned b);
        if (s) begin
            loc_valid = v;
            loc_data  = b;
        end else begin
            rx_valid = v;
            rx_data  = b;
        end
    endtask

    // Valid stays high across a full FIFO; the byte only advances once it was offered while ready.
    task automatic run_src(input bit s, input bit rnd);
        byte unsigned b;
        int g;
        while ((s ? stim1.size() : stim0.size()) != 0) begin
            if (s) b = stim1.pop_front();
            else   b = stim0.pop_front();
            if (rnd && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                drive(s, 1'b0, 8'h00);
                repeat ($urandom_range(1, 24)) @(negedge clk);
            end
            @(negedge clk);
            drive(s, 1'b1, b);
            g = 0;
            while (!(s ? loc_ready : rx_ready) && g <= 500) begin
                @(negedge clk);
                g++;
            end
            if (g > 500) begin
                note_fail("drv_stuck", "source never became ready");
                break;
            end
        end
        @(negedge clk);
        drive(s, 1'b0, 8'h00);
    endtask

    task automatic clear_logs();
        obs_log.delete();
        obs_cyc.delete();
        to_log.delete();
        dir_exp.delete();
        saw_loc_full = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((mq0.size() != 0 || mq1.size() != 0 || m_esc.size() != 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) note_fail("idle_wait", "traffic did not drain");
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_log(input string name);
        chk({name, "_len"}, obs_log.size(), dir_exp.size());
        for (int i = 0; i < dir_exp.size() && i < obs_log.size(); i++)
            chk(name, obs_log[i], dir_exp[i]);
        dir_exp.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_dataReady"}, dataReady, 0);
        chk({tag, "_lock_active"}, lock_active, 0);
        chk({tag, "_lock_owner"}, lock_owner, 1);
        chk({tag, "_lock_timeout"}, lock_timeout, 0);
        chk({tag, "_rx_ready"}, rx_ready, 1);
        chk({tag, "_loc_ready"}, loc_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Single byte from rx.
        do_reset();
        add(0, 8'h41);
        run_src(0, 1'b0);
        wait_idle();
        dexp(8'h41);
        cmp_log("single");

        // Round-robin across two preloaded sources.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            add(0, 8'(8'h61 + i));
            add(1, 8'(8'h71 + i));
        end
        fork
            run_src(0, 1'b0);
            run_src(1, 1'b0);
        join
        wait_idle();
        for (int i = 1; i < obs_cyc.size(); i++)
            chk("rr_spacing", obs_cyc[i] - obs_cyc[i-1], GAP + 1);
        dexp(8'h61); dexp(8'h71); dexp(8'h62); dexp(8'h72); dexp(8'h63); dexp(8'h73);
        cmp_log("rr");

        // Escape lock holds the parser for the whole CSI sequence.
        do_reset();
        add(0, 8'h1B); add(0, 8'h5B); add(0, 8'h31); add(0, 8'h3B); add(0, 8'h32); add(0, 8'h48);
        fork
            run_src(0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                add(1, 8'h58);
                run_src(1, 1'b0);
            end
        join
        wait_idle();
        dexp(8'h1B); dexp(8'h5B); dexp(8'h31); dexp(8'h3B); dexp(8'h32); dexp(8'h48); dexp(8'h58);
        cmp_log("lock");

        // Stalled sequence forced open by the timeout.
        do_reset();
        add(0, 8'h1B); add(0, 8'h5B);
        fork
            run_src(0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                add(1, 8'h58);
                run_src(1, 1'b0);
            end
        join
        wait_idle();
        chk("to_count", to_log.size(), 1);
        if (to_log.size() >= 1 && obs_cyc.size() >= 3) begin
            chk("to_delay", to_log[0] - obs_cyc[1], LT);
            chk("to_resume", obs_cyc[2] - to_log[0], 1);
        end
        dexp(8'h1B); dexp(8'h5B); dexp(8'h58);
        cmp_log("timeout");

        // loc FIFO fills while rx holds the lock; nothing lost or duplicated.
        do_reset();
        add(0, 8'h1B); add(0, 8'h5B);
        fork
            run_src(0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 6; i++) add(1, 8'(8'h80 + i));
                run_src(1, 1'b0);
            end
        join
        wait_idle();
        chk("loc_full_seen", saw_loc_full, 1);
        dexp(8'h1B); dexp(8'h5B);
        for (int i = 0; i < 6; i++) dexp(8'(8'h80 + i));
        cmp_log("full");

        // Asynchronous reset in the middle of a CSI sequence.
        do_reset();
        add(0, 8'h1B); add(0, 8'h5B); add(0, 8'h31); add(0, 8'h32);
        add(1, 8'h58); add(1, 8'h58);
        fork
            run_src(0, 1'b0);
            run_src(1, 1'b0);
        join
        g = 0;
        while (obs_log.size() < 2 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) note_fail("csi_wait", "5B never issued");
        @(posedge clk);
        #3;
        chk("pre_rst_lock", lock_active, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        add(0, 8'h10);
        add(1, 8'h20);
        fork
            run_src(0, 1'b0);
            run_src(1, 1'b0);
        join
        wait_idle();
        dexp(8'h10); dexp(8'h20);
        cmp_log("post_rst");

        // Randomized mixed traffic with random stalls.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 10; i++) begin
                add(0, pick());
                add(1, pick());
            end
            fork
                run_src(0, 1'b1);
                run_src(1, 1'b1);
            join
            wait_idle();
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
